// File: rtl/lcv_div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcv_div_pkg;

    // FSM encoding kept as plain constants so older tools and wave viewers see stable values.
    typedef logic [1:0] div_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Widest operand the conditional-negate helper supports.
    localparam int NEG_MAX_W = 64;

    // Step counter must hold WIDTH-1 (counts down to zero).
    function automatic int step_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Two's-complement negate when en is set. Operands narrower than 64 bits are
    // zero-extended by the caller; the low bits of the result are still the correct
    // modular negation, so callers simply truncate back to their width.
    function automatic logic [NEG_MAX_W-1:0] cond_neg(input logic [NEG_MAX_W-1:0] v,
                                                      input logic en);
        return en ? (~v + {{(NEG_MAX_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/lcv_div_step.sv
// One radix-2 restoring division step: shift in next dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step result is registered.
module lcv_div_step
    import lcv_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             n_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_out,
    output logic             qbit
);

    // The shifted remainder can reach 2*D-1, so compare/subtract is one bit wider than
    // the operands; after a successful subtract the result is back below D and fits WIDTH.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // Trial subtract and restore-or-keep selection.
    always_comb begin
        shifted = {r_in, n_msb};
        ge      = (shifted >= {1'b0, d});
        diff    = shifted - {1'b0, d};
        qbit    = ge;
        r_out   = WIDTH'(ge ? diff : shifted);
    end

endmodule

// File: rtl/lcv_div_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned per op; optional LCV_DIV_FAST_SPECIAL_EN.
// Latency: result after edge t+WIDTH+1 from accept edge t (t+1 for /0 and MIN/-1 when fast path built).
// Backpressure: result held in DONE until out_ready; in_ready low from accept until result taken.
module lcv_div_iter
    import lcv_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_numer,
    input  logic [WIDTH-1:0] in_denom,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_div_zero
);

    localparam int               CW      = step_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_q;      // partial remainder (magnitude)
    logic [WIDTH-1:0] n_q;      // dividend magnitude; quotient bits shift in from the bottom
    logic [WIDTH-1:0] d_q;      // divisor magnitude
    logic             qneg_q;   // quotient must be negated at the end
    logic             rneg_q;   // remainder takes the (negative) dividend sign
    logic             dz_q;     // divisor was zero

    logic             numer_neg;
    logic             denom_neg;
    logic             denom_zero;
    logic [WIDTH-1:0] numer_mag;
    logic [WIDTH-1:0] denom_mag;
    logic             fast_special;
    logic [WIDTH-1:0] step_r;
    logic             step_q;

    assign in_ready = (state == ST_IDLE);

    // Operand conditioning at accept: sign capture and magnitudes (|MIN| stays as 2^(WIDTH-1)).
    always_comb begin
        numer_neg    = in_signed & in_numer[WIDTH-1];
        denom_neg    = in_signed & in_denom[WIDTH-1];
        denom_zero   = (in_denom == '0);
        numer_mag    = WIDTH'(cond_neg(NEG_MAX_W'(in_numer), numer_neg));
        denom_mag    = WIDTH'(cond_neg(NEG_MAX_W'(in_denom), denom_neg));
        fast_special = 1'b0;
`ifdef LCV_DIV_FAST_SPECIAL_EN
        // Divide-by-zero and MIN/-1 have closed-form answers, so skip the iteration.
        fast_special = denom_zero |
                       (in_signed && (in_numer == MIN_VAL) && (in_denom == '1));
`endif
    end

    lcv_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in  (r_q),
        .n_msb (n_q[WIDTH-1]),
        .d     (d_q),
        .r_out (step_r),
        .qbit  (step_q)
    );

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            r_q          <= '0;
            n_q          <= '0;
            d_q          <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            dz_q         <= 1'b0;
            out_valid    <= 1'b0;
            out_quot     <= '0;
            out_rem      <= '0;
            out_div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        qneg_q <= numer_neg ^ denom_neg;
                        rneg_q <= numer_neg;
                        dz_q   <= denom_zero;
                        d_q    <= denom_mag;
                        cnt    <= CW'(WIDTH - 1);
                        if (fast_special) begin
                            // Preload exactly what the full iteration would leave behind:
                            // /0 -> all-ones quotient, remainder = |numer|;
                            // MIN/-1 -> quotient magnitude |MIN|, remainder 0.
                            n_q   <= denom_zero ? '1 : numer_mag;
                            r_q   <= denom_zero ? numer_mag : '0;
                            state <= ST_FIX;
                        end else begin
                            n_q   <= numer_mag;
                            r_q   <= '0;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_q <= step_r;
                    n_q <= {n_q[WIDTH-2:0], step_q};
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    // Divide-by-zero quotient is forced: the sign fix-up would otherwise
                    // negate the all-ones magnitude for a negative dividend.
                    out_quot     <= dz_q ? '1 : WIDTH'(cond_neg(NEG_MAX_W'(n_q), qneg_q));
                    out_rem      <= WIDTH'(cond_neg(NEG_MAX_W'(r_q), rneg_q));
                    out_div_zero <= dz_q;
                    out_valid    <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcv_div_iter.sv
// Directed bench for lcv_div_iter: arithmetic model + per-cycle output monitor + literal pins.
// Latency: checks full and special-case latency for the build in use.
// Backpressure: holds out_ready low and checks the result stays put with in_ready low.
module tb_lcv_div_iter;

    localparam int          W        = 32;
    localparam logic [31:0] MIN_VAL  = 32'h8000_0000;
    localparam int          LAT_FULL = W + 1;
`ifdef LCV_DIV_FAST_SPECIAL_EN
    localparam int          LAT_SPEC = 1;
`else
    localparam int          LAT_SPEC = W + 1;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  in_numer;
    logic [W-1:0]  in_denom;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_quot;
    logic [W-1:0]  out_rem;
    logic          out_div_zero;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    lcv_div_iter #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_numer     (in_numer),
        .in_denom     (in_denom),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quot     (out_quot),
        .out_rem      (out_rem),
        .out_div_zero (out_div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic (SV / and % truncate toward zero like the divider).
    function automatic exp_t model(input logic sg, input logic [31:0] n, input logic [31:0] d);
        exp_t   e;
        longint a;
        longint b;
        if (d == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = n; e.dz = 1'b1;
        end else if (sg && n == MIN_VAL && d == 32'hFFFF_FFFF) begin
            e.q = MIN_VAL; e.r = 32'd0; e.dz = 1'b0;
        end else begin
            if (sg) begin
                a = longint'($signed(n));
                b = longint'($signed(d));
            end else begin
                a = longint'({32'd0, n});
                b = longint'({32'd0, d});
            end
            e.q = 32'(a / b); e.r = 32'(a % b); e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: whenever a result is presented it must match the oldest outstanding op.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_spurious: out_valid=1 with no op outstanding");
            end else begin
                chk("mon_quot", 64'(out_quot), 64'(exp_q[0].q));
                chk("mon_rem", 64'(out_rem), 64'(exp_q[0].r));
                chk("mon_dz", 64'(out_div_zero), 64'(exp_q[0].dz));
                chk("mon_in_ready_low", 64'(in_ready), 64'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one op (called just after a posedge with the divider idle), measure latency,
    // hold the result for 'hold' cycles, then take it.
    task automatic run_op(input logic sg, input logic [31:0] n, input logic [31:0] d,
                          input int hold, output logic [31:0] q, output logic [31:0] r,
                          output logic dz);
        int  lat;
        int  exp_lat;
        bit  special;
        special = (d == 32'd0) || (sg && n == MIN_VAL && d == 32'hFFFF_FFFF);
        exp_lat = special ? LAT_SPEC : LAT_FULL;
        in_signed = sg; in_numer = n; in_denom = d; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("accept_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(model(sg, n, d));
        #1;
        in_valid  = 1'b0;
        in_numer  = $urandom;
        in_denom  = $urandom;
        in_signed = 1'($urandom_range(0, 1));
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            chk("busy_in_ready_low", 64'(in_ready), 64'd0);
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL latency_timeout: no out_valid within 100 cycles");
        end else begin
            chk("latency", 64'(lat), 64'(exp_lat));
        end
        q = out_quot; r = out_rem; dz = out_div_zero;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin : main
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;

        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_numer = '0; in_denom = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_quot", 64'(out_quot), 64'd0);
        chk("rst_rem", 64'(out_rem), 64'd0);
        chk("rst_dz", 64'(out_div_zero), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 32'd100, 32'd7, 0, q, r, dz);
        chk("u100_7_q", 64'(q), 64'd14);
        chk("u100_7_r", 64'(r), 64'd2);
        chk("u100_7_dz", 64'(dz), 64'd0);

        run_op(1'b1, -32'sd100, 32'd7, 0, q, r, dz);
        chk("sm100_7_q", 64'(q), 64'(32'hFFFF_FFF2));
        chk("sm100_7_r", 64'(r), 64'(32'hFFFF_FFFE));

        run_op(1'b1, 32'd100, -32'sd7, 0, q, r, dz);
        chk("s100_m7_q", 64'(q), 64'(32'hFFFF_FFF2));
        chk("s100_m7_r", 64'(r), 64'd2);

        run_op(1'b1, -32'sd5, 32'd0, 0, q, r, dz);
        chk("sdz_q", 64'(q), 64'(32'hFFFF_FFFF));
        chk("sdz_r", 64'(r), 64'(32'hFFFF_FFFB));
        chk("sdz_dz", 64'(dz), 64'd1);

        run_op(1'b0, 32'd5, 32'd0, 0, q, r, dz);
        chk("udz_r", 64'(r), 64'd5);

        run_op(1'b1, MIN_VAL, 32'hFFFF_FFFF, 0, q, r, dz);
        chk("smin_m1_q", 64'(q), 64'(32'h8000_0000));
        chk("smin_m1_r", 64'(r), 64'd0);

        run_op(1'b0, MIN_VAL, 32'hFFFF_FFFF, 0, q, r, dz);
        chk("umin_ff_q", 64'(q), 64'd0);
        chk("umin_ff_r", 64'(r), 64'(32'h8000_0000));

        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, q, r, dz);
        chk("ubigd_q", 64'(q), 64'd1);
        chk("ubigd_r", 64'(r), 64'(32'h7FFF_FFFE));

        run_op(1'b1, -32'sd100, -32'sd7, 0, q, r, dz);
        chk("sm100_m7_q", 64'(q), 64'd14);
        chk("sm100_m7_r", 64'(r), 64'(32'hFFFF_FFFE));

        // Backpressure: result held ten cycles with out_ready low (monitor checks every cycle).
        run_op(1'b1, -32'sd7, 32'd2, 10, q, r, dz);
        chk("bp_q", 64'(q), 64'(32'hFFFF_FFFD));
        chk("bp_r", 64'(r), 64'(32'hFFFF_FFFF));

        // Reset in the middle of CALC: op must vanish without a result.
        in_signed = 1'b0; in_numer = 32'd1000; in_denom = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        chk("rstmid_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_out_valid", 64'(out_valid), 64'd0);
        chk("rstmid_in_ready", 64'(in_ready), 64'd1);
        chk("rstmid_quot", 64'(out_quot), 64'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 32'hFFFF_FFFF, 32'd16, 0, q, r, dz);
        chk("after_rst_q", 64'(q), 64'(32'h0FFF_FFFF));
        chk("after_rst_r", 64'(r), 64'd15);

        repeat (5) @(posedge clk);
        chk("all_results_seen", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
